// File: rtl/frame_xfer_sched_pkg.sv
// Shared definitions for the pixel transfer scheduler: state encoding,
// default address widths and requester indices.
package xfer_defs;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } xfer_state_e;

  localparam int ROW_W_DEF = 8;
  localparam int COL_W_DEF = 9;

  localparam int REQ_MASK = 0;
  localparam int REQ_HOST = 1;

endpackage

// File: rtl/frame_xfer_sched_rr_arb2.sv
// Two-way round-robin picker: the requester that was not served last wins
// if it is asking, otherwise whichever one is asking.
module rr_arb2
  import xfer_defs::*;
(
  input  logic [1:0] req,
  input  logic       last,
  output logic       win,
  output logic       any
);

  localparam logic HOST = 1'(REQ_HOST);
  localparam logic MASK = 1'(REQ_MASK);

  logic other;

  always_comb begin
    any   = |req;
    other = (last == HOST) ? MASK : HOST;
    if (req[other]) win = other;
    else            win = last;
  end

endmodule

// File: rtl/frame_xfer_sched.sv
// Whole-frame scheduler: grants one requester, raster-scans row/col with a
// strobe under sink back-pressure, then pulses done (optionally aborted).
//
// state | meaning
// IDLE  | waiting for a request; grant and latch frame size on the same edge
// SCAN  | strobe asserted, address advances on each accepted beat
// DONE  | one-cycle done pulse, grant still held, round-robin pointer updated
module frame_xfer_sched
  import xfer_defs::*;
#(
  parameter int ROW_W = ROW_W_DEF,
  parameter int COL_W = COL_W_DEF,
  parameter int NREQ  = 2
) (
  input  logic             Clock,
  input  logic             nReset,
  input  logic [NREQ-1:0]  req,
  input  logic [ROW_W-1:0] cfg_rows,
  input  logic [COL_W-1:0] cfg_cols,
  input  logic             abort,
  input  logic             sink_ready,
  output logic [NREQ-1:0]  gnt,
  output logic             busy,
  output logic [ROW_W-1:0] pix_row,
  output logic [COL_W-1:0] pix_col,
  output logic             strobe,
  output logic             line_end,
  output logic             done,
  output logic             aborted
);

  xfer_state_e state_q, state_d;

  logic             last_q, last_d;
  logic             win_q, win_d;
  logic [ROW_W-1:0] rows_q, rows_d;
  logic [COL_W-1:0] cols_q, cols_d;
  logic [ROW_W-1:0] row_q, row_d;
  logic [COL_W-1:0] col_q, col_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             strobe_q, strobe_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             aborted_q, aborted_d;

  logic arb_win, arb_any;
  logic col_last, row_last;

  rr_arb2 u_arb (
    .req  (req[1:0]),
    .last (last_q),
    .win  (arb_win),
    .any  (arb_any)
  );

  assign col_last = (col_q == cols_q - COL_W'(1));
  assign row_last = (row_q == rows_q - ROW_W'(1));

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    win_d     = win_q;
    rows_d    = rows_q;
    cols_d    = cols_q;
    row_d     = row_q;
    col_d     = col_q;
    gnt_d     = gnt_q;
    strobe_d  = strobe_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    aborted_d = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (arb_any) begin
          win_d  = arb_win;
          rows_d = cfg_rows;
          cols_d = cfg_cols;
          row_d  = '0;
          col_d  = '0;
          gnt_d  = NREQ'(1) << arb_win;
          // an empty frame is granted and closed without a single strobe
          if (cfg_rows == '0 || cfg_cols == '0) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d  = SCAN;
            strobe_d = 1'b1;
            busy_d   = 1'b1;
          end
        end
      end
      SCAN: begin
        if (abort) begin
          state_d   = DONE;
          strobe_d  = 1'b0;
          busy_d    = 1'b0;
          done_d    = 1'b1;
          aborted_d = 1'b1;
        end else if (sink_ready) begin
          if (col_last && row_last) begin
            state_d  = DONE;
            strobe_d = 1'b0;
            busy_d   = 1'b0;
            done_d   = 1'b1;
          end else if (col_last) begin
            col_d = '0;
            row_d = row_q + ROW_W'(1);
          end else begin
            col_d = col_q + COL_W'(1);
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
        last_d  = win_q;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      last_q    <= 1'b1;
      win_q     <= 1'b0;
      rows_q    <= '0;
      cols_q    <= '0;
      row_q     <= '0;
      col_q     <= '0;
      gnt_q     <= '0;
      strobe_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      aborted_q <= 1'b0;
    end else begin
      last_q    <= last_d;
      win_q     <= win_d;
      rows_q    <= rows_d;
      cols_q    <= cols_d;
      row_q     <= row_d;
      col_q     <= col_d;
      gnt_q     <= gnt_d;
      strobe_q  <= strobe_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      aborted_q <= aborted_d;
    end
  end

  assign gnt      = gnt_q;
  assign busy     = busy_q;
  assign pix_row  = row_q;
  assign pix_col  = col_q;
  assign strobe   = strobe_q;
  assign done     = done_q;
  assign aborted  = aborted_q;
  // gated by busy so the flag never shows outside a scan
  assign line_end = busy_q && col_last;

endmodule
